systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one operand element.
REQ-002 Parameter LANES, default 4: number of skewed output lanes (array rows or columns fed).
REQ-003 Parameter DEPTH, default 4: number of operand vectors buffered per operation (reduction length K).
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 flush  input  1: synchronous abort; returns the block to IDLE and empties the buffer.
REQ-007 load_valid  input  1: load_data holds a valid vector.
REQ-008 load_ready  output  1: block accepts a vector this cycle.
REQ-009 load_data  input  LANES*DATA_WIDTH: one vector; lane i element at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 start  input  1: request to stream the buffered vectors.
REQ-011 busy  output  1: streaming or done phase in progress.
REQ-012 done  output  1: single-cycle completion pulse.
REQ-013 out_data  output  LANES*DATA_WIDTH: skewed operands; lane i drives array edge input i.
REQ-014 lane_valid  output  LANES: per-lane accumulate enable, aligned with out_data.

Function
REQ-015 States SHALL be IDLE, STREAM, DONE, encoded in one state register.
REQ-016 The buffer SHALL hold DEPTH vectors written in arrival order with write count wr_count (0..DEPTH).
REQ-017 In IDLE, load_ready SHALL be 1 iff wr_count < DEPTH; it SHALL be 0 in STREAM and DONE.
REQ-018 A vector SHALL be written to slot wr_count, and wr_count incremented, on each edge with load_valid && load_ready.
REQ-019 start SHALL be accepted only in IDLE with wr_count == DEPTH; otherwise it SHALL be ignored without side effects.
REQ-020 When start and load_valid are both high in IDLE with wr_count < DEPTH, the load SHALL be taken and start ignored.
REQ-021 On start acceptance the block SHALL enter STREAM with step counter t = 0.
REQ-022 In STREAM, t SHALL increment each cycle from 0 to DEPTH+LANES-2, then the block SHALL enter DONE.
REQ-023 In STREAM, lane_valid[i] SHALL be 1 iff 0 <= t-i < DEPTH, and lane i of out_data SHALL equal element i of vector (t-i).
REQ-024 Whenever lane_valid[i] is 0, lane i of out_data SHALL be 0.
REQ-025 out_data and lane_valid SHALL derive only from registered state (no combinational input-to-output path).
REQ-026 First valid beat (lane 0, vector 0) SHALL appear the cycle immediately after the start-accept edge; the stream lasts exactly DEPTH+LANES-1 cycles.
REQ-027 DONE SHALL last exactly one cycle with done = 1, then go to IDLE with wr_count = 0.
REQ-028 busy SHALL be 1 in STREAM and DONE, 0 in IDLE.
REQ-029 Buffer contents SHALL not change during STREAM or DONE.
REQ-030 flush SHALL override all other inputs: next state IDLE, wr_count = 0, t = 0, all outputs at reset values; done SHALL not pulse.
REQ-031 Counter widths SHALL hold DEPTH+LANES-1 and DEPTH without wrap; no arithmetic is performed on data.

Reset
REQ-032 On rst assertion, regardless of clock, state SHALL be IDLE, wr_count = 0, t = 0, out_data = 0, lane_valid = 0, done = 0, busy = 0.
REQ-033 While rst is held and after release, load_ready SHALL be 1; buffer data need not be cleared.
REQ-034 rst asserted mid-STREAM SHALL abort immediately with no done pulse; a new operation SHALL require DEPTH fresh loads.

Verification
REQ-035 LANES=4, DEPTH=4, load vectors Vk with element i = 16'h(k)(i), start -> over 7 cycles lane_valid = 0001,0011,0111,1111,1110,1100,1000; lane i carries V(t-i)[i]; done pulses on cycle 8.
REQ-036 start with wr_count = 2 -> ignored, busy stays 0; two more loads then start -> normal stream.
REQ-037 load_valid held high through a full buffer and streaming -> exactly 4 loads accepted, load_ready = 0 from the 4th accept until after done.
REQ-038 flush asserted at stream cycle 3 -> next cycle IDLE, lane_valid = 0, out_data = 0, load_ready = 1, no done pulse.
REQ-039 rst asserted asynchronously between clock edges mid-STREAM -> outputs zero before the next edge; after release wr_count = 0.
REQ-040 Back-to-back operations: after done, reload 4 vectors and start -> second stream identical in timing to the first with new data.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand skew buffer for a systolic array: collects DEPTH vectors, then streams
// them diagonally so lane i sees vector (t-i) on step t, with a per-lane valid.
module systolic_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   load_data,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]              lane_valid
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(DEPTH + LANES);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] WR_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] T_LAST  = TW'(DEPTH + LANES - 2);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]                    state;
    logic [CW-1:0]                 wr_count;
    logic [TW-1:0]                 t;
    logic [LANES*DATA_WIDTH-1:0]   buf_mem [DEPTH];
    logic                          load_fire;
    logic                          start_fire;

    assign load_ready = (state == IDLE) && (wr_count < WR_FULL);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // A load wins over start simply because start only counts once the buffer is full.
    assign load_fire  = load_valid && load_ready && !flush;
    assign start_fire = start && (state == IDLE) && (wr_count == WR_FULL) && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_count <= '0;
            t        <= '0;
        end else if (flush) begin
            state    <= IDLE;
            wr_count <= '0;
            t        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_fire) begin
                        state <= STREAM;
                        t     <= '0;
                    end else if (load_fire) begin
                        wr_count <= wr_count + CW'(1);
                    end
                end
                STREAM: begin
                    if (t == T_LAST) begin
                        state <= DONE;
                        t     <= '0;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    wr_count <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the buffer is deliberately not reset; wr_count alone decides which
    // slots hold live data, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (load_fire)
            buf_mem[wr_count[AW-1:0]] <= load_data;
    end

    // Each lane reads vector (t - i); outside its window the lane is forced to zero.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [TW-1:0] rel;
        logic          in_window;

        assign rel       = t - TW'(i);
        assign in_window = (state == STREAM) && (t >= TW'(i)) && (rel < TW'(DEPTH));

        assign lane_valid[i] = in_window;
        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] =
            in_window ? buf_mem[rel[AW-1:0]][i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: expected skewed beats are queued at start
// and popped one per stream cycle; inputs change and outputs are sampled on negedge.
module tb_systolic_feeder;

    localparam int DW     = 16;
    localparam int LANES  = 4;
    localparam int DEPTH  = 4;
    localparam int NBEATS = DEPTH + LANES - 1;
    localparam int VW     = LANES * DW;

    typedef struct packed {
        logic [LANES-1:0] lv;
        logic [VW-1:0]    data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             load_valid;
    logic             load_ready;
    logic [VW-1:0]    load_data;
    logic             start;
    logic             busy;
    logic             done;
    logic [VW-1:0]    out_data;
    logic [LANES-1:0] lane_valid;

    int checks = 0;
    int passes = 0;

    beat_t         exp_q[$];
    logic [VW-1:0] model_buf [DEPTH];
    int            model_wr = 0;

    logic [LANES-1:0] lv_tab [NBEATS] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                          4'b1110, 4'b1100, 4'b1000};

    systolic_feeder #(.DATA_WIDTH(DW), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .out_data   (out_data),
        .lane_valid (lane_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] make_vec(input int k);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++)
            v[i*DW +: DW] = {8'(k), 8'(i)};
        return v;
    endfunction

    task automatic load_vec(input string name, input logic [VW-1:0] v);
        checks++;
        if (load_ready !== 1'b1) $display("FAIL %s load_ready got %b want 1", name, load_ready);
        else passes++;
        load_valid = 1'b1;
        load_data  = v;
        @(negedge clk);
        load_valid = 1'b0;
        model_buf[model_wr] = v;
        model_wr++;
    endtask

    task automatic load_all(input string name, input int base);
        for (int k = 0; k < DEPTH; k++)
            load_vec(name, make_vec(base + k));
    endtask

    task automatic push_stream();
        beat_t b;
        for (int s = 0; s < NBEATS; s++) begin
            b = '0;
            for (int i = 0; i < LANES; i++) begin
                if (s - i >= 0 && s - i < DEPTH) begin
                    b.lv[i] = 1'b1;
                    b.data[i*DW +: DW] = model_buf[s-i][i*DW +: DW];
                end
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic start_op();
        start = 1'b1;
        push_stream();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_one_beat(input string name);
        beat_t b;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL %s scoreboard empty while beat expected", name);
            return;
        end
        b = exp_q.pop_front();
        checks++;
        if (lane_valid !== b.lv) $display("FAIL %s lane_valid got %b want %b", name, lane_valid, b.lv);
        else passes++;
        checks++;
        if (out_data !== b.data) $display("FAIL %s out_data got %h want %h", name, out_data, b.data);
        else passes++;
        checks++;
        if ({busy, done, load_ready} !== 3'b100)
            $display("FAIL %s busy/done/load_ready got %b want 100", name, {busy, done, load_ready});
        else passes++;
    endtask

    task automatic check_beats(input string name, input int n);
        repeat (n) begin
            check_one_beat(name);
            @(negedge clk);
        end
    endtask

    task automatic check_tail(input string name);
        checks++;
        if ({busy, done, load_ready, lane_valid} !== {3'b110, 4'b0000})
            $display("FAIL %s done-cycle busy/done/ready/lv got %b want 1100000",
                     name, {busy, done, load_ready, lane_valid});
        else passes++;
        @(negedge clk);
        checks++;
        if ({busy, done, load_ready} !== 3'b001)
            $display("FAIL %s post-done busy/done/ready got %b want 001", name, {busy, done, load_ready});
        else passes++;
        model_wr = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, load_ready, lane_valid, out_data} !== {3'b001, {LANES{1'b0}}, {VW{1'b0}}})
            $display("FAIL reset_held outputs got %b%b%b %b %h want 001 0000 0",
                     busy, done, load_ready, lane_valid, out_data);
        else passes++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, load_ready, lane_valid} !== {3'b001, 4'b0000})
            $display("FAIL reset_release outputs got %b want 0010000", {busy, done, load_ready, lane_valid});
        else passes++;
    endtask

    task automatic test_stream();
        load_all("stream_load", 0);
        start_op();
        for (int s = 0; s < NBEATS; s++) begin
            checks++;
            if (lane_valid !== lv_tab[s]) $display("FAIL stream_pattern t=%0d got %b want %b", s, lane_valid, lv_tab[s]);
            else passes++;
            check_one_beat("stream");
            @(negedge clk);
        end
        check_tail("stream");
    endtask

    task automatic test_start_ignored();
        load_vec("ign_load", make_vec(8'h10));
        load_vec("ign_load", make_vec(8'h11));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, load_ready} !== 2'b01) $display("FAIL start_partial busy/ready got %b want 01", {busy, load_ready});
        else passes++;
        start = 1'b1;
        load_vec("ign_load_with_start", make_vec(8'h12));
        start = 1'b0;
        checks++;
        if ({busy, load_ready} !== 2'b01) $display("FAIL start_with_load busy/ready got %b want 01", {busy, load_ready});
        else passes++;
        load_vec("ign_load", make_vec(8'h13));
        start_op();
        check_beats("ign_stream", NBEATS);
        check_tail("ign_stream");
    endtask

    task automatic test_load_hold();
        load_valid = 1'b1;
        for (int n = 0; n < DEPTH; n++) begin
            checks++;
            if (load_ready !== 1'b1) $display("FAIL hold_ready n=%0d got %b want 1", n, load_ready);
            else passes++;
            load_data = make_vec(8'h20 + n);
            @(negedge clk);
            model_buf[model_wr] = load_data;
            model_wr++;
        end
        checks++;
        if (load_ready !== 1'b0) $display("FAIL hold_full_ready got %b want 0", load_ready);
        else passes++;
        load_data = make_vec(8'h99);
        start_op();
        check_beats("hold_stream", NBEATS);
        check_tail("hold_stream");
        load_valid = 1'b0;
    endtask

    task automatic test_flush();
        load_all("flush_load", 8'h30);
        start_op();
        check_beats("flush_stream", 3);
        check_one_beat("flush_stream");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if ({busy, done, load_ready, lane_valid, out_data} !== {3'b001, {LANES{1'b0}}, {VW{1'b0}}})
            $display("FAIL flush_outputs got %b%b%b %b %h want 001 0000 0",
                     busy, done, load_ready, lane_valid, out_data);
        else passes++;
        exp_q.delete();
        model_wr = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) $display("FAIL flush_no_done busy/done got %b want 00", {busy, done});
        else passes++;
    endtask

    task automatic test_async_reset();
        load_all("areset_load", 8'h40);
        start_op();
        check_beats("areset_stream", 2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, load_ready, lane_valid, out_data} !== {3'b001, {LANES{1'b0}}, {VW{1'b0}}})
            $display("FAIL areset_outputs got %b%b%b %b %h want 001 0000 0",
                     busy, done, load_ready, lane_valid, out_data);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_wr = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done, load_ready} !== 3'b001)
            $display("FAIL areset_start_ignored busy/done/ready got %b want 001", {busy, done, load_ready});
        else passes++;
        load_all("areset_reload", 8'h50);
        start_op();
        check_beats("areset_restream", NBEATS);
        check_tail("areset_restream");
    endtask

    task automatic test_back_to_back();
        load_all("b2b_load_a", 8'h60);
        start_op();
        check_beats("b2b_stream_a", NBEATS);
        check_tail("b2b_stream_a");
        load_all("b2b_load_b", 8'h70);
        start_op();
        check_beats("b2b_stream_b", NBEATS);
        check_tail("b2b_stream_b");
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;

        test_reset();
        test_stream();
        test_start_ignored();
        test_load_hold();
        test_flush();
        test_async_reset();
        test_back_to_back();

        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        else passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
